// File: rtl/fft_buf_pkg.sv
// fft_buf_pkg: shared types and constants for the transpose buffer.
//   bank_state_e   - per-bank occupancy state (empty, filling, readable)
//   MODE_TRANSPOSE - column read-out of a stored block
//   MODE_STRAIGHT  - row read-out of a stored block
package fft_buf_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFill  = 2'd1,
    StRead  = 2'd2
  } bank_state_e;

  localparam logic MODE_TRANSPOSE = 1'b0;
  localparam logic MODE_STRAIGHT  = 1'b1;

endpackage

// File: rtl/transpose_bank.sv
// transpose_bank: one LANES x LANES word store with row write and row/column read.
// Ports:
//   clk      - clock
//   we       - write wr_data into row wr_row
//   wr_row   - row index written
//   wr_data  - LANES packed words, lane k at [k*WORD_W +: WORD_W]
//   rd_idx   - output beat index (column in transpose mode, row in straight mode)
//   rd_mode  - MODE_TRANSPOSE or MODE_STRAIGHT
//   rd_data  - LANES packed words of the selected column or row
// Storage is intentionally not reset.
module transpose_bank
  import fft_buf_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter int unsigned WORD_W = 34,
  parameter int unsigned IDX_W  = $clog2(LANES)
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [IDX_W-1:0]          wr_row,
  input  logic [LANES*WORD_W-1:0]   wr_data,
  input  logic [IDX_W-1:0]          rd_idx,
  input  logic                      rd_mode,
  output logic [LANES*WORD_W-1:0]   rd_data
);

  logic [LANES*WORD_W-1:0] mem_q [LANES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_row] <= wr_data;
    end
  end

  // Straight: lane i = W[idx][i]; transpose: lane i = W[i][idx].
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (rd_mode == MODE_STRAIGHT) begin
        rd_data[i*WORD_W +: WORD_W] = mem_q[rd_idx][i*WORD_W +: WORD_W];
      end else begin
        rd_data[i*WORD_W +: WORD_W] = mem_q[i][rd_idx*WORD_W +: WORD_W];
      end
    end
  end

endmodule

// File: rtl/transpose_buf.sv
// transpose_buf: block buffer that stores LANES beats of LANES words and replays
// them either transposed (columns) or straight (rows).
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   clr                  - synchronous abort of all blocks in flight
//   mode                 - read-out mode, captured with beat 0 of each block
//   in_valid/in_ready    - input beat handshake, in_data lanes packed by WORD_W
//   out_valid/out_ready  - output beat handshake, out_data packed like in_data
//   out_last             - marks beat LANES-1 of a block
// Build option: define TRANSPOSE_BUF_PINGPONG_EN for two banks so one block can
// fill while the previous one drains; otherwise a single bank is used.
module transpose_buf
  import fft_buf_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter int unsigned WORD_W = 34
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*WORD_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*WORD_W-1:0] out_data,
  output logic                    out_last
);

  localparam int unsigned IdxW  = $clog2(LANES);
  localparam int unsigned DataW = LANES * WORD_W;
`ifdef TRANSPOSE_BUF_PINGPONG_EN
  localparam int unsigned NumBanks = 2;
`else
  localparam int unsigned NumBanks = 1;
`endif
  localparam int unsigned PtrW = 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(LANES - 1);

  bank_state_e          state_q [NumBanks];
  logic                 mode_q  [NumBanks];
  logic [DataW-1:0]     bank_rd_data [NumBanks];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [IdxW-1:0]      wr_idx_q, rd_idx_q;
  logic                 in_fire, out_fire;

  // Single-bank builds keep both pointers pinned at bank 0.
  function automatic logic [PtrW-1:0] next_ptr(logic [PtrW-1:0] ptr);
    return (NumBanks > 1) ? ptr + 1'b1 : '0;
  endfunction

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    for (int unsigned b = 0; b < NumBanks; b++) begin
      if (wr_ptr_q == PtrW'(b)) begin
        in_ready = rst_n && (state_q[b] != StRead);
      end
      if (rd_ptr_q == PtrW'(b)) begin
        out_valid = (state_q[b] == StRead);
        out_data  = bank_rd_data[b];
      end
    end
    out_last = out_valid && (rd_idx_q == LastIdx);
  end

  // clr wins over any handshake in the same cycle.
  assign in_fire  = in_valid && in_ready && !clr;
  assign out_fire = out_valid && out_ready && !clr;

  for (genvar g = 0; g < NumBanks; g++) begin : g_bank
    transpose_bank #(
      .LANES  (LANES),
      .WORD_W (WORD_W),
      .IDX_W  (IdxW)
    ) u_bank (
      .clk     (clk),
      .we      (in_fire && (wr_ptr_q == PtrW'(g))),
      .wr_row  (wr_idx_q),
      .wr_data (in_data),
      .rd_idx  (rd_idx_q),
      .rd_mode (mode_q[g]),
      .rd_data (bank_rd_data[g])
    );
  end

  // Bank FSMs: Empty -> Fill on beat 0, Fill -> Read on beat LANES-1,
  // Read -> Empty when beat LANES-1 drains. The write and read banks can only
  // coincide while the bank is not Read, so fill and drain never collide.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int unsigned b = 0; b < NumBanks; b++) begin
        state_q[b] <= StEmpty;
        mode_q[b]  <= MODE_TRANSPOSE;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
    end else begin
      if (in_fire) begin
        wr_idx_q <= wr_idx_q + 1'b1;
        for (int unsigned b = 0; b < NumBanks; b++) begin
          if (wr_ptr_q == PtrW'(b)) begin
            if (wr_idx_q == '0) begin
              state_q[b] <= StFill;
              mode_q[b]  <= mode;
            end
            if (wr_idx_q == LastIdx) begin
              state_q[b] <= StRead;
            end
          end
        end
        if (wr_idx_q == LastIdx) begin
          wr_ptr_q <= next_ptr(wr_ptr_q);
        end
      end
      if (out_fire) begin
        rd_idx_q <= rd_idx_q + 1'b1;
        if (rd_idx_q == LastIdx) begin
          for (int unsigned b = 0; b < NumBanks; b++) begin
            if (rd_ptr_q == PtrW'(b)) begin
              state_q[b] <= StEmpty;
            end
          end
          rd_ptr_q <= next_ptr(rd_ptr_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_transpose_buf.sv
// tb_transpose_buf: directed self-checking bench for transpose_buf (LANES=4,
// WORD_W=34). Word value of block blk, row r, lane c is 16*blk + 4*r + c.
module tb_transpose_buf;

  localparam int unsigned LANES  = 4;
  localparam int unsigned WORD_W = 34;
  localparam int unsigned DW     = LANES * WORD_W;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          clr       = 1'b0;
  logic          mode      = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data   = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  transpose_buf #(
    .LANES  (LANES),
    .WORD_W (WORD_W)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  function automatic logic [WORD_W-1:0] word(int blk, int r, int c);
    return WORD_W'(16 * blk + 4 * r + c);
  endfunction

  function automatic logic [DW-1:0] beat_in(int blk, int r);
    logic [DW-1:0] d;
    for (int c = 0; c < LANES; c++) d[c*WORD_W +: WORD_W] = word(blk, r, c);
    return d;
  endfunction

  // Transpose: lane i = W[i][j]; straight: lane i = W[j][i].
  function automatic logic [DW-1:0] beat_out(int blk, int j, logic m);
    logic [DW-1:0] d;
    for (int i = 0; i < LANES; i++) begin
      d[i*WORD_W +: WORD_W] = m ? word(blk, j, i) : word(blk, i, j);
    end
    return d;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mode is flipped on beats 1..3 so any late sampling shows up in the data.
  task automatic send_block(input int blk, input logic m);
    for (int r = 0; r < LANES; r++) begin
      int cnt = 0;
      in_valid = 1'b1;
      in_data  = beat_in(blk, r);
      mode     = (r == 0) ? m : ~m;
      while (!in_ready && cnt < 50) begin
        step();
        cnt++;
      end
      if (cnt >= 50) check("in_ready_timeout", 1'b0, 1'b1);
      if (r == LANES - 1) check("no_early_valid", out_valid, 1'b0);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain_block(input int blk, input logic m);
    out_ready = 1'b1;
    for (int j = 0; j < LANES; j++) begin
      int cnt = 0;
      while (!out_valid && cnt < 50) begin
        step();
        cnt++;
      end
      if (cnt >= 50) check("out_valid_timeout", 1'b0, 1'b1);
      check("out_data", out_data, beat_out(blk, j, m));
      check("out_last", out_last, (j == LANES - 1));
      step();
    end
  endtask

  initial begin
    // Reset state.
    step();
    step();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    step();

    // One block, transpose mode, hand values for beats 0 and 3.
    out_ready = 1'b1;
    send_block(0, 1'b0);
    check("latency_valid", out_valid, 1'b1);
    check("t_b0_lane0", out_data[0*WORD_W +: WORD_W], 34'd0);
    check("t_b0_lane1", out_data[1*WORD_W +: WORD_W], 34'd4);
    check("t_b0_lane3", out_data[3*WORD_W +: WORD_W], 34'd12);
    for (int j = 0; j < LANES - 1; j++) step();
    check("t_b3_lane0", out_data[0*WORD_W +: WORD_W], 34'd3);
    check("t_b3_lane3", out_data[3*WORD_W +: WORD_W], 34'd15);
    check("t_b3_last", out_last, 1'b1);
    step();
    check("t_done_valid", out_valid, 1'b0);
    check("t_done_in_ready", in_ready, 1'b1);

    // Same block, straight mode, full model compare.
    send_block(0, 1'b1);
    check("s_b0_lane0", out_data[0*WORD_W +: WORD_W], 34'd0);
    check("s_b0_lane3", out_data[3*WORD_W +: WORD_W], 34'd3);
    drain_block(0, 1'b1);
    check("s_done_valid", out_valid, 1'b0);

    // Back-pressure for 10 cycles.
    out_ready = 1'b0;
    send_block(2, 1'b0);
`ifdef TRANSPOSE_BUF_PINGPONG_EN
    check("pp_second_bank_ready", in_ready, 1'b1);
    send_block(3, 1'b1);
`endif
    for (int k = 0; k < 10; k++) begin
      check("stall_valid", out_valid, 1'b1);
      check("stall_data", out_data, beat_out(2, 0, 1'b0));
      check("stall_last", out_last, 1'b0);
      check("stall_in_ready", in_ready, 1'b0);
      step();
    end
    drain_block(2, 1'b0);
`ifdef TRANSPOSE_BUF_PINGPONG_EN
    drain_block(3, 1'b1);
`endif
    check("stall_done_valid", out_valid, 1'b0);

    // Abort a partial block; clr overrides a same-cycle handshake.
    in_valid = 1'b1;
    in_data  = beat_in(7, 0);
    step();
    in_data  = beat_in(7, 1);
    step();
    in_data  = beat_in(7, 2);
    clr      = 1'b1;
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    check("clr_out_valid", out_valid, 1'b0);
    check("clr_in_ready", in_ready, 1'b1);
    send_block(1, 1'b0);
    drain_block(1, 1'b0);
    step();
    check("clr_done_valid", out_valid, 1'b0);

    // Reset while draining at beat index 2.
    send_block(2, 1'b1);
    out_ready = 1'b1;
    for (int j = 0; j < 2; j++) begin
      check("pre_rst_data", out_data, beat_out(2, j, 1'b1));
      step();
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1'b0);
    step();
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_last", out_last, 1'b0);
    rst_n = 1'b1;
    #1;
    check("after_rst_in_ready", in_ready, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      check("no_stale_beat", out_valid, 1'b0);
    end

`ifdef TRANSPOSE_BUF_PINGPONG_EN
    // Three blocks back-to-back: no input stall and no output bubble.
    out_ready = 1'b1;
    fork
      begin
        for (int b = 0; b < 3; b++) begin
          for (int r = 0; r < LANES; r++) begin
            in_valid = 1'b1;
            in_data  = beat_in(4 + b, r);
            mode     = 1'b0;
            check("pp_in_ready", in_ready, 1'b1);
            step();
          end
        end
        in_valid = 1'b0;
      end
      begin
        int cnt = 0;
        while (!out_valid && cnt < 50) begin
          step();
          cnt++;
        end
        if (cnt >= 50) check("pp_valid_timeout", 1'b0, 1'b1);
        for (int k = 0; k < 12; k++) begin
          check("pp_out_valid", out_valid, 1'b1);
          check("pp_out_data", out_data, beat_out(4 + k / 4, k % 4, 1'b0));
          check("pp_out_last", out_last, ((k % 4) == 3));
          step();
        end
        check("pp_done_valid", out_valid, 1'b0);
      end
    join
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/transpose_buf.md
TRANSPOSE_BUF -- requirements
Module: transpose_buf

Interface
REQ-001 Parameter LANES, default 4: words per beat and beats per block (power of two, >=2).
REQ-002 Parameter WORD_W, default 34: bits per word (complex sample, re/im packed).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 clr  input  1  synchronous block abort; active-high.
REQ-006 mode  input  1  0 = transpose (column read-out), 1 = straight (row read-out); sampled per block.
REQ-007 in_valid  input  1  in_data beat valid.
REQ-008 in_ready  output  1  block can accept a beat.
REQ-009 in_data  input  LANES*WORD_W  lane k at bits [k*WORD_W +: WORD_W].
REQ-010 out_valid  output  1  out_data beat valid.
REQ-011 out_ready  input  1  downstream accepts beat.
REQ-012 out_data  output  LANES*WORD_W  same lane packing as in_data.
REQ-013 out_last  output  1  high with final beat (index LANES-1) of a block.

Function
REQ-014 Block = LANES beats of LANES words; storage word W[r][c] = lane c of accepted input beat r.
REQ-015 Input handshake when in_valid && in_ready; beat index r counts 0..LANES-1, wraps to 0 after last beat.
REQ-016 mode SHALL be sampled on the handshake of beat r=0 and held with that block until fully drained.
REQ-017 Output beat j, transpose mode: out lane i = W[i][j]; straight mode: out lane i = W[j][i].
REQ-018 Output handshake when out_valid && out_ready; j counts 0..LANES-1; out_last = out_valid && j==LANES-1.
REQ-019 Each bank FSM: EMPTY -> FILL (beat 0 accepted) -> READ (beat LANES-1 accepted) -> EMPTY (beat LANES-1 drained).
REQ-020 EMPTY->READ directly when LANES beats are... not allowed; FILL always traversed, even for back-to-back beats.
REQ-021 Latency: out_valid SHALL be 1 in the cycle immediately after the edge accepting input beat LANES-1.
REQ-022 out_data/out_last/out_valid SHALL hold stable while out_valid && !out_ready.
REQ-023 in_ready = write bank state != READ; in_ready SHALL be 0 while rst_n is 0.
REQ-024 No data is lost or overwritten: a bank in READ is never written.
REQ-025 clr SHALL return all banks to EMPTY, r=j=0, drop any partial or undrained block; clr overrides same-cycle handshakes; storage contents not cleared.
REQ-026 With LANES=4, WORD_W=34, mode=0, behaviour SHALL be beat-for-beat identical to the existing 4x4 FFT intermediate buffer output ordering.

Reset
REQ-027 On rst_n=0 at a clock edge: all banks EMPTY, write/read bank pointers 0, r=j=0, out_valid=0, out_last=0.
REQ-028 out_data after reset is don't-care while out_valid=0; storage SHALL NOT be reset.
REQ-029 Reset mid-block discards the block with no partial output beat.

Configuration
REQ-030 Macro TRANSPOSE_BUF_PINGPONG_EN defined: two banks; write pointer toggles on entering READ, read pointer toggles on leaving READ; one block may fill while the other drains; in_ready drops only when both banks are in READ.
REQ-031 Macro undefined: single bank; in_ready=0 throughout READ, returns to 1 the cycle after the last beat drains.
REQ-032 PINGPONG simultaneous case: last drain of bank A and last fill of bank B on the same edge SHALL make B readable next cycle with no bubble (out_valid stays 1).

Structure
REQ-033 Package fft_buf_pkg SHALL hold the bank state enum (EMPTY/FILL/READ) and mode constants MODE_TRANSPOSE=0, MODE_STRAIGHT=1.
REQ-034 Sub-module transpose_bank SHALL hold one LANESxLANES storage array with row write and row/column read mux; transpose_buf instantiates one or two.
REQ-035 Index counters SHALL be $clog2(LANES) bits wide.

Verification (LANES=4, WORD_W=34, word value = 16*blk+4*r+c)
REQ-036 One block mode=0, out_ready=1 -> beats {W30,W20,W10,W00}..{W33,W23,W13,W03}, out_valid first cycle after beat 3, out_last on beat 3.
REQ-037 Same block mode=1 -> beats in input order, lane 0 of beat 0 = 0, lane 3 of beat 3 = 15.
REQ-038 PINGPONG, 3 blocks back-to-back, out_ready=1 -> in_ready never drops, 12 output beats contiguous, no bubble.
REQ-039 out_ready=0 for 10 cycles during drain -> out_data held; single-bank build in_ready=0 throughout; pingpong in_ready=0 after second block fills.
REQ-040 clr after 2 input beats, then new block -> only new block emitted, values 16..31 reordered per REQ-017.
REQ-041 rst_n=0 while bank in READ at j=2 -> out_valid=0 next cycle, in_ready=1 after rst_n rises, no stale beats emitted.
